// File: rtl/fft_pkg.sv
// fft_pkg: constants and width helper shared by the FFT pipeline stages.
package fft_pkg;
  localparam int FFT_POINTS = 8;
  localparam int FFT_LOG2 = 3;
  function automatic int width(input int n);
    return 2 ** n;
  endfunction
endpackage

// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: serial sample stream in, parallel frame out, plus framing error.
interface fft_input_loader_if
  import fft_pkg::*;
#(
  parameter int N = 4
);
  localparam int W = width(N);
  logic [W-1:0] in_data;
  logic in_valid;
  logic in_first;
  logic in_ready;
  logic [W-1:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
  logic out_valid;
  logic out_ready;
  logic err;
  modport master (
    output in_data, in_valid, in_first, out_ready,
    input in_ready, out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_valid, err
  );
  modport slave (
    input in_data, in_valid, in_first, out_ready,
    output in_ready, out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_valid, err
  );
endinterface

// File: rtl/fft_frame_bank.sv
// fft_frame_bank: one frame of registers, single indexed write, all words readable in parallel.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [FFT_LOG2-1:0] idx,
  input  logic [W-1:0]        wdata,
  output logic [W-1:0]        rdata [FFT_POINTS]
);
  logic [W-1:0] mem_q [FFT_POINTS];
  logic [W-1:0] mem_d [FFT_POINTS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign rdata = mem_q;
endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: assembles 8-sample frames into a ping-pong buffer and presents them in parallel.
module fft_input_loader
  import fft_pkg::*;
#(
  parameter int N = 4
) (
  input logic clk,
  input logic rst,
  fft_input_loader_if.slave bus
);
  localparam int W = width(N);
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, err_q, err_d;
  logic [FFT_LOG2-1:0] wr_idx_q, wr_idx_d, widx;
  logic [1:0] full_q, full_d;
  logic accept, restart, done, rel;
  logic [W-1:0] rd0 [FFT_POINTS];
  logic [W-1:0] rd1 [FFT_POINTS];
  logic [W-1:0] sel [FFT_POINTS];
  always_comb begin
    accept = bus.in_valid && !full_q[wr_bank_q];
    restart = accept && bus.in_first && wr_idx_q != '0;
    widx = restart ? '0 : wr_idx_q;
    done = accept && widx == '1;
    rel = full_q[rd_bank_q] && bus.out_ready;
    wr_idx_d = accept ? widx + 1'b1 : wr_idx_q;
    wr_bank_d = wr_bank_q ^ done;
    rd_bank_d = rd_bank_q ^ rel;
    err_d = err_q | restart;
    full_d = full_q;
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (done) full_d[wr_bank_q] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q <= '0;
      full_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q <= wr_idx_d;
      full_q <= full_d;
      err_q <= err_d;
    end
  fft_frame_bank #(.W(W)) u_bank0 (
    .clk(clk), .rst(rst), .we(accept && !wr_bank_q), .idx(widx), .wdata(bus.in_data), .rdata(rd0)
  );
  fft_frame_bank #(.W(W)) u_bank1 (
    .clk(clk), .rst(rst), .we(accept && wr_bank_q), .idx(widx), .wdata(bus.in_data), .rdata(rd1)
  );
  always_comb
    for (int k = 0; k < FFT_POINTS; k++) sel[k] = rd_bank_q ? rd1[k] : rd0[k];
  assign bus.in_ready = !full_q[wr_bank_q];
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.err = err_q;
  assign bus.out_0 = sel[0];
  assign bus.out_1 = sel[1];
  assign bus.out_2 = sel[2];
  assign bus.out_3 = sel[3];
  assign bus.out_4 = sel[4];
  assign bus.out_5 = sel[5];
  assign bus.out_6 = sel[6];
  assign bus.out_7 = sel[7];
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: random and directed streams scored against a frame-queue reference model.
module tb_fft_input_loader;
  localparam int N = 4;
  localparam int W = 2 ** N;
  logic clk = 0;
  logic rst = 1;
  fft_input_loader_if #(.N(N)) bus ();
  fft_input_loader #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  logic [W-1:0] outs [8];
  assign outs[0] = bus.out_0;
  assign outs[1] = bus.out_1;
  assign outs[2] = bus.out_2;
  assign outs[3] = bus.out_3;
  assign outs[4] = bus.out_4;
  assign outs[5] = bus.out_5;
  assign outs[6] = bus.out_6;
  assign outs[7] = bus.out_7;
  logic [8*W-1:0] exp_q[$];
  logic [W-1:0] part[$];
  logic err_exp = 0;
  logic rdy_ok = 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] d, input logic f);
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_first = f;
    step();
    bus.in_valid = 0;
    bus.in_first = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  // Reference model: frames are whole 8-sample groups; a first flag on a partial frame restarts it.
  initial forever begin
    @(posedge clk);
    if (!rst && bus.in_valid && rdy_ok) begin
      if (bus.in_first && part.size() != 0) begin
        part.delete();
        err_exp = 1;
      end
      part.push_back(bus.in_data);
      if (part.size() == 8) begin
        logic [8*W-1:0] f;
        for (int k = 0; k < 8; k++) f[k*W +: W] = part[k];
        exp_q.push_back(f);
        part.delete();
      end
    end
  end
  initial forever begin
    @(posedge rst);
    exp_q.delete();
    part.delete();
    err_exp = 0;
    rdy_ok = 1;
  end
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      chk("err", 32'(bus.err), 32'(err_exp));
      rdy_ok = exp_q.size() < 2;
      if (bus.out_ready && exp_q.size() > 0) begin
        logic [8*W-1:0] f;
        f = exp_q.pop_front();
        for (int k = 0; k < 8; k++) chk($sformatf("out_%0d", k), 32'(outs[k]), 32'(f[k*W +: W]));
      end
    end
  end
  initial begin
    int drops;
    bus.in_valid = 0;
    bus.in_first = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_err", 32'(bus.err), 0);
    for (int k = 0; k < 8; k++) chk("rst_out", 32'(outs[k]), 0);
    idle(2);
    rst = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) send(W'(i + 1), i == 0);
    chk("lat_valid_hi", 32'(bus.out_valid), 1);
    chk("lat_out_0", 32'(bus.out_0), 1);
    chk("lat_out_7", 32'(bus.out_7), 8);
    step();
    chk("lat_valid_lo", 32'(bus.out_valid), 0);
    idle(2);
    bus.out_ready = 0;
    for (int i = 0; i < 24; i++) begin
      send(W'(i + 1), i % 8 == 0);
      if (i == 15) chk("hold_ready_drop", 32'(bus.in_ready), 0);
    end
    chk("hold_frame1_0", 32'(bus.out_0), 1);
    chk("hold_frame1_7", 32'(bus.out_7), 8);
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    chk("hold_frame2_0", 32'(bus.out_0), 9);
    chk("hold_frame2_7", 32'(bus.out_7), 16);
    chk("hold_ready_back", 32'(bus.in_ready), 1);
    bus.out_ready = 1;
    idle(3);
    drops = 0;
    for (int i = 0; i < 80; i++) begin
      if (!bus.in_ready) drops++;
      send(W'($urandom), i % 8 == 0);
    end
    chk("stream_no_drop", 32'(drops), 0);
    idle(3);
    for (int i = 0; i < 3; i++) send(W'($urandom), i == 0);
    send(W'(5), 1);
    for (int i = 0; i < 7; i++) send(W'($urandom), 0);
    idle(2);
    chk("restart_err", 32'(bus.err), 1);
    bus.out_ready = 0;
    for (int i = 0; i < 13; i++) send(W'($urandom), i % 8 == 0);
    #2;
    rst = 1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    chk("arst_err", 32'(bus.err), 0);
    for (int k = 0; k < 8; k++) chk("arst_out", 32'(outs[k]), 0);
    step();
    rst = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) send(W'(8'hA0 + i), i == 0);
    idle(2);
    for (int i = 0; i < 8; i++) send(i % 2 ? W'(16'h7FFF) : W'(16'h8000), i == 0);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.in_first = ($urandom % 16) == 0;
      bus.in_data = W'($urandom);
      bus.out_ready = $urandom % 2;
      step();
    end
    bus.in_valid = 0;
    bus.in_first = 0;
    bus.out_ready = 1;
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
